// File: rtl/dda_column_buffer_if.sv
// Bus bundle between the DDA result producers / renderer and the column buffer.
// The master side drives result strobes, frame starts and read requests.
// The slave side is the buffer itself.
interface dda_column_buffer_if;
    // DDA result strobe and payload
    logic        valid_in;
    logic [8:0]  hcount_ray_in;
    logic [15:0] lineHeight_in;
    logic        wallType_in;
    logic [3:0]  mapData_in;
    logic [15:0] wallX_in;

    // Renderer frame start and read request
    logic        frame_start_in;
    logic        rd_en_in;
    logic [8:0]  rd_hcount_in;

    // Read response
    logic        rd_valid_out;
    logic [15:0] rd_lineHeight_out;
    logic        rd_wallType_out;
    logic [3:0]  rd_mapData_out;
    logic [15:0] rd_wallX_out;

    // Status towards the ray generator and for debug
    logic        frame_request_out;
    logic        write_full_out;
    logic [8:0]  cols_received_out;
    logic [7:0]  frame_skip_count_out;
    logic        drop_err_out;

    modport master (
        output valid_in, hcount_ray_in, lineHeight_in, wallType_in, mapData_in, wallX_in,
        output frame_start_in, rd_en_in, rd_hcount_in,
        input  rd_valid_out, rd_lineHeight_out, rd_wallType_out, rd_mapData_out, rd_wallX_out,
        input  frame_request_out, write_full_out, cols_received_out, frame_skip_count_out,
        input  drop_err_out
    );

    modport slave (
        input  valid_in, hcount_ray_in, lineHeight_in, wallType_in, mapData_in, wallX_in,
        input  frame_start_in, rd_en_in, rd_hcount_in,
        output rd_valid_out, rd_lineHeight_out, rd_wallType_out, rd_mapData_out, rd_wallX_out,
        output frame_request_out, write_full_out, cols_received_out, frame_skip_count_out,
        output drop_err_out
    );
endinterface

// File: rtl/dda_column_buffer.sv
// Double-buffered per-column result store sitting after the DDA stage.
// Results may arrive out of order; a bitmap tracks which columns of the write
// bank have arrived. The banks swap at renderer frame start only when the
// write bank is complete, after which the next ray frame is requested.
module dda_column_buffer #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    dda_column_buffer_if.slave     bus
);
    localparam int          MEM_DEPTH = 2 * SCREEN_WIDTH;
    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [8:0]  WIDTH_9   = 9'(SCREEN_WIDTH);

    // Column index is 9 bits and lineHeight is 16 bits, which bounds the geometry
    if (SCREEN_WIDTH > 511 || SCREEN_WIDTH < 1 || SCREEN_HEIGHT > 65535) begin : g_bad_geometry
        $error("dda_column_buffer: unsupported screen geometry");
    end

    // Entry layout: {lineHeight, wallType, mapData, wallX}
    logic [36:0] mem [0:MEM_DEPTH-1];

    logic                    read_bank;
    logic                    write_bank;
    logic                    shown_valid;
    logic                    started;
    logic [SCREEN_WIDTH-1:0] seen;

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    swap;
    logic [AW-1:0]           wr_addr;
    logic [AW-1:0]           rd_addr;
    logic [36:0]             wr_entry;
    logic [36:0]             rd_entry;

    assign write_bank  = ~read_bank;
    assign wr_in_range = (bus.hcount_ray_in < WIDTH_9);
    assign rd_in_range = (bus.rd_hcount_in < WIDTH_9);
    assign swap        = bus.frame_start_in & bus.write_full_out;

    // Bank-major layout: bank 1 occupies the upper SCREEN_WIDTH entries
    assign wr_addr  = AW'(bus.hcount_ray_in) + (write_bank ? AW'(SCREEN_WIDTH) : AW'(0));
    assign rd_addr  = AW'(bus.rd_hcount_in)  + (read_bank  ? AW'(SCREEN_WIDTH) : AW'(0));
    assign wr_entry = {bus.lineHeight_in, bus.wallType_in, bus.mapData_in, bus.wallX_in};
    assign rd_entry = mem[rd_addr];

    // Column storage write; contents are intentionally not reset
    always_ff @(posedge pixel_clk_in) begin
        if (bus.valid_in && wr_in_range) begin
            mem[wr_addr] <= wr_entry;
        end
    end

    // Bank control, arrival tracking, frame requests and error/skip status
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            read_bank                <= 1'b0;
            shown_valid              <= 1'b0;
            started                  <= 1'b0;
            seen                     <= '0;
            bus.cols_received_out    <= '0;
            bus.write_full_out       <= 1'b0;
            bus.frame_skip_count_out <= '0;
            bus.drop_err_out         <= 1'b0;
            bus.frame_request_out    <= 1'b0;
        end else begin
            bus.frame_request_out <= 1'b0;
            started               <= 1'b1;
            if (!started) begin
                bus.frame_request_out <= 1'b1;
            end

            if (bus.valid_in && !wr_in_range) begin
                bus.drop_err_out <= 1'b1;
            end

            if (swap) begin
                // A write landing in this cycle went to the bank now being shown
                read_bank             <= ~read_bank;
                shown_valid           <= 1'b1;
                seen                  <= '0;
                bus.cols_received_out <= '0;
                bus.write_full_out    <= 1'b0;
                bus.frame_request_out <= 1'b1;
            end else begin
                if (bus.frame_start_in && bus.frame_skip_count_out != 8'hFF) begin
                    bus.frame_skip_count_out <= bus.frame_skip_count_out + 8'd1;
                end
                if (bus.valid_in && wr_in_range && !seen[bus.hcount_ray_in]) begin
                    seen[bus.hcount_ray_in] <= 1'b1;
                    bus.cols_received_out   <= bus.cols_received_out + 9'd1;
                    bus.write_full_out      <= ((bus.cols_received_out + 9'd1) == WIDTH_9);
                end
            end
        end
    end

    // One-cycle read port from the currently shown bank; fields are zero when invalid
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus.rd_valid_out      <= 1'b0;
            bus.rd_lineHeight_out <= '0;
            bus.rd_wallType_out   <= 1'b0;
            bus.rd_mapData_out    <= '0;
            bus.rd_wallX_out      <= '0;
        end else if (bus.rd_en_in && shown_valid && rd_in_range) begin
            bus.rd_valid_out      <= 1'b1;
            bus.rd_lineHeight_out <= rd_entry[36:21];
            bus.rd_wallType_out   <= rd_entry[20];
            bus.rd_mapData_out    <= rd_entry[19:16];
            bus.rd_wallX_out      <= rd_entry[15:0];
        end else begin
            bus.rd_valid_out      <= 1'b0;
            bus.rd_lineHeight_out <= '0;
            bus.rd_wallType_out   <= 1'b0;
            bus.rd_mapData_out    <= '0;
            bus.rd_wallX_out      <= '0;
        end
    end
endmodule

// File: tb/tb_dda_column_buffer.sv
// Directed self-checking bench for dda_column_buffer.
module tb_dda_column_buffer;
    logic clk;
    logic rst_n;
    int   assert_count;
    int   fail_count;

    dda_column_buffer_if bus ();

    dda_column_buffer #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240)) dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .bus          (bus)
    );

    // 10 ns pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_col(input logic [8:0] h, input logic [15:0] lh, input logic wt,
                             input logic [3:0] md, input logic [15:0] wx);
        bus.valid_in      = 1'b1;
        bus.hcount_ray_in = h;
        bus.lineHeight_in = lh;
        bus.wallType_in   = wt;
        bus.mapData_in    = md;
        bus.wallX_in      = wx;
        step();
        bus.valid_in      = 1'b0;
    endtask

    task automatic read_col(input logic [8:0] h);
        bus.rd_en_in     = 1'b1;
        bus.rd_hcount_in = h;
        step();
        bus.rd_en_in     = 1'b0;
    endtask

    task automatic pulse_frame_start();
        bus.frame_start_in = 1'b1;
        step();
        bus.frame_start_in = 1'b0;
    endtask

    task automatic test_reset();
        bus.valid_in = 0; bus.hcount_ray_in = 0; bus.lineHeight_in = 0; bus.wallType_in = 0;
        bus.mapData_in = 0; bus.wallX_in = 0; bus.frame_start_in = 0; bus.rd_en_in = 0;
        bus.rd_hcount_in = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        assert_count++;
        if (bus.cols_received_out !== 9'd0 || bus.write_full_out !== 1'b0 || bus.drop_err_out !== 1'b0
            || bus.frame_skip_count_out !== 8'd0 || bus.rd_valid_out !== 1'b0 || bus.frame_request_out !== 1'b0) begin
            $display("[TB] FAIL reset_state: cols=%0d full=%0d drop=%0d skip=%0d rdv=%0d req=%0d required all 0",
                     bus.cols_received_out, bus.write_full_out, bus.drop_err_out,
                     bus.frame_skip_count_out, bus.rd_valid_out, bus.frame_request_out);
            fail_count++;
        end
        rst_n = 1'b1;
        step();
        assert_count++;
        if (bus.frame_request_out !== 1'b1) begin
            $display("[TB] FAIL startup_request: got %0b required 1", bus.frame_request_out);
            fail_count++;
        end
        step();
        assert_count++;
        if (bus.frame_request_out !== 1'b0) begin
            $display("[TB] FAIL startup_request_width: got %0b required 0", bus.frame_request_out);
            fail_count++;
        end
        read_col(9'd5);
        assert_count++;
        if (bus.rd_valid_out !== 1'b0 || bus.rd_lineHeight_out !== 16'd0) begin
            $display("[TB] FAIL read_before_frame: valid=%0b lh=%0d required 0/0",
                     bus.rd_valid_out, bus.rd_lineHeight_out);
            fail_count++;
        end
    endtask

    task automatic test_full_frame();
        for (int h = 319; h >= 0; h--) begin
            write_col(9'(h), 16'(h + 100), 1'(h), 4'(h), 16'(h * 3));
        end
        assert_count++;
        if (bus.cols_received_out !== 9'd320 || bus.write_full_out !== 1'b1) begin
            $display("[TB] FAIL full_before_swap: cols=%0d full=%0b required 320/1",
                     bus.cols_received_out, bus.write_full_out);
            fail_count++;
        end
        pulse_frame_start();
        assert_count++;
        if (bus.frame_request_out !== 1'b1 || bus.cols_received_out !== 9'd0 || bus.write_full_out !== 1'b0) begin
            $display("[TB] FAIL swap_effect: req=%0b cols=%0d full=%0b required 1/0/0",
                     bus.frame_request_out, bus.cols_received_out, bus.write_full_out);
            fail_count++;
        end
        read_col(9'd37);
        assert_count++;
        if (bus.frame_request_out !== 1'b0) begin
            $display("[TB] FAIL swap_request_width: got %0b required 0", bus.frame_request_out);
            fail_count++;
        end
        assert_count++;
        if (bus.rd_valid_out !== 1'b1 || bus.rd_lineHeight_out !== 16'd137 || bus.rd_wallType_out !== 1'b1
            || bus.rd_mapData_out !== 4'd5 || bus.rd_wallX_out !== 16'd111) begin
            $display("[TB] FAIL read_col37: valid=%0b lh=%0d wt=%0b md=%0d wx=%0d required 1/137/1/5/111",
                     bus.rd_valid_out, bus.rd_lineHeight_out, bus.rd_wallType_out,
                     bus.rd_mapData_out, bus.rd_wallX_out);
            fail_count++;
        end
        read_col(9'd320);
        assert_count++;
        if (bus.rd_valid_out !== 1'b0 || bus.rd_lineHeight_out !== 16'd0) begin
            $display("[TB] FAIL read_out_of_range: valid=%0b lh=%0d required 0/0",
                     bus.rd_valid_out, bus.rd_lineHeight_out);
            fail_count++;
        end
    endtask

    task automatic test_incomplete_frame();
        for (int h = 0; h < 319; h++) begin
            write_col(9'(h), 16'(h + 1000), 1'b0, 4'd0, 16'd0);
        end
        write_col(9'd10, 16'd5555, 1'b1, 4'd9, 16'd42);
        assert_count++;
        if (bus.cols_received_out !== 9'd319 || bus.write_full_out !== 1'b0) begin
            $display("[TB] FAIL duplicate_count: cols=%0d full=%0b required 319/0",
                     bus.cols_received_out, bus.write_full_out);
            fail_count++;
        end
        pulse_frame_start();
        assert_count++;
        if (bus.frame_skip_count_out !== 8'd1 || bus.frame_request_out !== 1'b0 || bus.cols_received_out !== 9'd319) begin
            $display("[TB] FAIL skip_frame: skip=%0d req=%0b cols=%0d required 1/0/319",
                     bus.frame_skip_count_out, bus.frame_request_out, bus.cols_received_out);
            fail_count++;
        end
        read_col(9'd10);
        assert_count++;
        if (bus.rd_valid_out !== 1'b1 || bus.rd_lineHeight_out !== 16'd110) begin
            $display("[TB] FAIL old_frame_read: valid=%0b lh=%0d required 1/110",
                     bus.rd_valid_out, bus.rd_lineHeight_out);
            fail_count++;
        end
    endtask

    task automatic test_drop_error();
        write_col(9'd320, 16'd1, 1'b0, 4'd0, 16'd0);
        assert_count++;
        if (bus.drop_err_out !== 1'b1 || bus.cols_received_out !== 9'd319) begin
            $display("[TB] FAIL drop_err_set: drop=%0b cols=%0d required 1/319",
                     bus.drop_err_out, bus.cols_received_out);
            fail_count++;
        end
        write_col(9'd319, 16'd1319, 1'b0, 4'd0, 16'd0);
        assert_count++;
        if (bus.drop_err_out !== 1'b1 || bus.cols_received_out !== 9'd320 || bus.write_full_out !== 1'b1) begin
            $display("[TB] FAIL drop_err_sticky: drop=%0b cols=%0d full=%0b required 1/320/1",
                     bus.drop_err_out, bus.cols_received_out, bus.write_full_out);
            fail_count++;
        end
    endtask

    task automatic test_back_to_back();
        bus.frame_start_in = 1'b1;
        write_col(9'd3, 16'd7777, 1'b1, 4'd7, 16'd77);
        bus.frame_start_in = 1'b0;
        assert_count++;
        if (bus.cols_received_out !== 9'd0 || bus.frame_request_out !== 1'b1 || bus.frame_skip_count_out !== 8'd1) begin
            $display("[TB] FAIL swap_with_write: cols=%0d req=%0b skip=%0d required 0/1/1",
                     bus.cols_received_out, bus.frame_request_out, bus.frame_skip_count_out);
            fail_count++;
        end
        read_col(9'd3);
        assert_count++;
        if (bus.rd_valid_out !== 1'b1 || bus.rd_lineHeight_out !== 16'd7777 || bus.rd_wallX_out !== 16'd77) begin
            $display("[TB] FAIL read_swap_write: valid=%0b lh=%0d wx=%0d required 1/7777/77",
                     bus.rd_valid_out, bus.rd_lineHeight_out, bus.rd_wallX_out);
            fail_count++;
        end
        read_col(9'd10);
        assert_count++;
        if (bus.rd_lineHeight_out !== 16'd5555 || bus.rd_mapData_out !== 4'd9) begin
            $display("[TB] FAIL read_dup_col: lh=%0d md=%0d required 5555/9",
                     bus.rd_lineHeight_out, bus.rd_mapData_out);
            fail_count++;
        end
        read_col(9'd319);
        assert_count++;
        if (bus.rd_lineHeight_out !== 16'd1319) begin
            $display("[TB] FAIL read_last_col: lh=%0d required 1319", bus.rd_lineHeight_out);
            fail_count++;
        end
    endtask

    task automatic test_mid_reset();
        for (int h = 0; h < 150; h++) begin
            write_col(9'(h), 16'(h), 1'b0, 4'd0, 16'd0);
        end
        read_col(9'd3);
        assert_count++;
        if (bus.cols_received_out !== 9'd150 || bus.rd_valid_out !== 1'b1) begin
            $display("[TB] FAIL before_mid_reset: cols=%0d rdv=%0b required 150/1",
                     bus.cols_received_out, bus.rd_valid_out);
            fail_count++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        assert_count++;
        if (bus.cols_received_out !== 9'd0 || bus.rd_valid_out !== 1'b0 || bus.rd_lineHeight_out !== 16'd0
            || bus.drop_err_out !== 1'b0 || bus.frame_skip_count_out !== 8'd0 || bus.write_full_out !== 1'b0) begin
            $display("[TB] FAIL async_reset: cols=%0d rdv=%0b lh=%0d drop=%0b skip=%0d full=%0b required all 0",
                     bus.cols_received_out, bus.rd_valid_out, bus.rd_lineHeight_out,
                     bus.drop_err_out, bus.frame_skip_count_out, bus.write_full_out);
            fail_count++;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        assert_count++;
        if (bus.frame_request_out !== 1'b1 || bus.cols_received_out !== 9'd0) begin
            $display("[TB] FAIL restart_request: req=%0b cols=%0d required 1/0",
                     bus.frame_request_out, bus.cols_received_out);
            fail_count++;
        end
        read_col(9'd3);
        assert_count++;
        if (bus.frame_request_out !== 1'b0 || bus.rd_valid_out !== 1'b0) begin
            $display("[TB] FAIL after_reset_read: req=%0b rdv=%0b required 0/0",
                     bus.frame_request_out, bus.rd_valid_out);
            fail_count++;
        end
    endtask

    // Scenario sequence
    initial begin
        assert_count = 0;
        fail_count   = 0;
        test_reset();
        test_full_frame();
        test_incomplete_frame();
        test_drop_error();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
